// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the dot-product MAC and its neighbours.
package mac_pkg;

  // Control states of the multiply-accumulate sequencer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } mac_state_e;

  // Result width that can never overflow: full product width plus
  // enough headroom bits to sum len products.
  function automatic int default_acc_w(input int width, input int len);
    return 2 * width + $clog2(len);
  endfunction

endpackage

// File: rtl/param_adder.sv
// N-bit ripple-carry adder, the generalised form of the old 4-bit carry adder.
module param_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out
);

  logic [N:0] carry;

  assign carry[0] = c_in;

  // One full adder per bit, carry rippling from LSB to MSB.
  for (genvar gi = 0; gi < N; gi++) begin : g_fa
    assign s[gi]       = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign c_out = carry[N];

endmodule

// File: rtl/dot_product_mac.sv
// Sequential dot-product unit: accumulates LEN unsigned products per vector
// over a valid/ready stream and presents one result with a sticky overflow.
module dot_product_mac
  import mac_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN   = 4,
  parameter int ACC_W = default_acc_w(WIDTH, LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(LEN - 1);

  mac_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic [PW-1:0]    prod;
  logic [ACC_W-1:0] prod_ext;
  logic             prod_hi;
  logic [ACC_W-1:0] add_s;
  logic             add_co;
  logic             beat;

  assign prod     = PW'(a) * PW'(b);
  assign prod_ext = ACC_W'(prod);

  // Product bits that do not fit the accumulator are an overflow in their own right.
  if (ACC_W < PW) begin : g_trunc
    assign prod_hi = |prod[PW-1:ACC_W];
  end else begin : g_fit
    assign prod_hi = 1'b0;
  end

  param_adder #(
    .N(ACC_W)
  ) u_adder (
    .a    (acc_q),
    .b    (prod_ext),
    .c_in (1'b0),
    .s    (add_s),
    .c_out(add_co)
  );

  // Operands are only taken while no result is pending.
  assign in_ready  = (state_q != DONE);
  assign beat      = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign sum       = acc_q;
  assign ovf       = ovf_q;

  // Next-state logic: accumulate accepted beats, hold the result until consumed.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (beat) begin
          acc_d = add_s;
          ovf_d = ovf_q | add_co | prod_hi;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          cnt_d       = '0;
          acc_d       = '0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        acc_d       = '0;
        ovf_d       = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset discards any partial accumulation immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
